// File: rtl/pending_request_encoder.sv
// Collects request pulses into a pending vector and serialises them as binary codes over a
// valid/ready handshake. Define ROUND_ROBIN_EN for round-robin selection (default: highest index).
module pending_request_encoder #(
  parameter int unsigned N = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic [N-1:0]         req_in,
  output logic [$clog2(N)-1:0] code_out,
  output logic                 valid,
  input  logic                 ready,
  output logic                 any_pending,
  output logic                 dup_pulse
);

  localparam int unsigned W = $clog2(N);

  typedef enum logic [0:0] {StEmpty, StHold} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   pending_q, pending_d;
  logic [N-1:0]   req_masked;
  logic [N-1:0]   clr;
  logic [W-1:0]   code_q, code_d;
  logic [W-1:0]   sel;
  logic           dup_q, dup_d;
  logic           has_pending;
  logic           load;
  logic           grant;

  assign req_masked  = req_in & {N{en}};
  assign has_pending = |pending_q;
  // The output slot is free when empty or when the consumer takes the current code.
  assign load        = (state_q == StEmpty) || ready;
  assign grant       = load && has_pending;

`ifdef ROUND_ROBIN_EN
  logic [W-1:0] last_q, last_d;
  logic [W-1:0] sel_hi, sel_lo;
  logic         hi_found;

  // Lowest pending index above the last grant, otherwise wrap to the lowest pending index.
  always_comb begin
    sel_hi   = '0;
    sel_lo   = '0;
    hi_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        sel_lo = W'(i);
        if (W'(i) > last_q) begin
          sel_hi   = W'(i);
          hi_found = 1'b1;
        end
      end
    end
    sel = hi_found ? sel_hi : sel_lo;
  end

  assign last_d = grant ? sel : last_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= W'(N - 1);
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Fixed priority: highest pending index wins.
  always_comb begin
    sel = '0;
    for (int i = 0; i < N; i++) begin
      if (pending_q[i]) begin
        sel = W'(i);
      end
    end
  end
`endif

  always_comb begin
    clr = '0;
    if (grant) begin
      clr[sel] = 1'b1;
    end
  end

  // A new request on the bit being cleared this cycle keeps it pending.
  assign pending_d = (pending_q & ~clr) | req_masked;
  assign dup_d     = |(req_masked & pending_q & ~clr);

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    unique case (state_q)
      StEmpty: begin
        if (has_pending) begin
          state_d = StHold;
          code_d  = sel;
        end
      end
      StHold: begin
        if (ready) begin
          if (has_pending) begin
            code_d = sel;
          end else begin
            state_d = StEmpty;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StEmpty;
      pending_q <= '0;
      code_q    <= '0;
      dup_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      code_q    <= code_d;
      dup_q     <= dup_d;
    end
  end

  assign code_out    = code_q;
  assign valid       = (state_q == StHold);
  assign any_pending = has_pending;
  assign dup_pulse   = dup_q;

`ifndef SYNTHESIS
  // A stalled code must not change under the consumer.
  hold_stable_a : assert property (@(posedge clk) disable iff (!reset_n)
    (valid && !ready) |=> (valid && $stable(code_out)));

  // Pending work is always picked up by an empty slot on the next edge.
  empty_loads_a : assert property (@(posedge clk) disable iff (!reset_n)
    (!valid && has_pending) |=> valid);
`endif

endmodule

// File: tb/tb_pending_request_encoder.sv
// Scoreboard bench for pending_request_encoder (N=4): expected codes are queued with the
// stimulus and popped by a monitor on each valid&&ready handshake.
module tb_pending_request_encoder;

  localparam int unsigned N = 4;

  logic         clk;
  logic         reset_n;
  logic         en;
  logic [N-1:0] req_in;
  logic [1:0]   code_out;
  logic         valid;
  logic         ready;
  logic         any_pending;
  logic         dup_pulse;

  int tests_run;
  int tests_failed;

  logic [1:0] exp_q[$];

  pending_request_encoder #(
    .N(N)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .req_in     (req_in),
    .code_out   (code_out),
    .valid      (valid),
    .ready      (ready),
    .any_pending(any_pending),
    .dup_pulse  (dup_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Delivery monitor: sees pre-edge values at each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      if (reset_n && valid && ready) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL delivery_unexpected: got code %0d, required no delivery", code_out);
        end else begin
          logic [1:0] e;
          e = exp_q.pop_front();
          if (code_out !== e) begin
            tests_failed++;
            $display("FAIL delivery_code: got %0d, required %0d", code_out, e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    exp_q.delete();
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    en      = 1'b1;
    req_in  = '0;
    ready   = 1'b0;
    repeat (3) step();
    tests_run++;
    if ({valid, code_out, any_pending, dup_pulse} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_held: got v=%0b c=%0d p=%0b d=%0b, required all 0",
               valid, code_out, any_pending, dup_pulse);
    end
    reset_n = 1'b1;
    step();
    step();
    tests_run++;
    if (valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_valid: got %0b, required 0", valid);
    end
    tests_run++;
    if (code_out !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_code: got %0d, required 0", code_out);
    end
    tests_run++;
    if (any_pending !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_any_pending: got %0b, required 0", any_pending);
    end
  endtask

  task automatic test_priority();
    logic [1:0] first;
    logic [1:0] second;
`ifdef ROUND_ROBIN_EN
    first  = 2'd0;
    second = 2'd2;
`else
    first  = 2'd2;
    second = 2'd0;
`endif
    ready  = 1'b1;
    req_in = 4'b0101;
    exp_q.push_back(first);
    exp_q.push_back(second);
    step();
    req_in = '0;
    tests_run++;
    if (any_pending !== 1'b1 || valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL prio_latency1: got p=%0b v=%0b, required p=1 v=0", any_pending, valid);
    end
    step();
    tests_run++;
    if (valid !== 1'b1 || code_out !== first) begin
      tests_failed++;
      $display("FAIL prio_first: got v=%0b c=%0d, required v=1 c=%0d", valid, code_out, first);
    end
    step();
    tests_run++;
    if (valid !== 1'b1 || code_out !== second) begin
      tests_failed++;
      $display("FAIL prio_second: got v=%0b c=%0d, required v=1 c=%0d", valid, code_out, second);
    end
    step();
    tests_run++;
    if (valid !== 1'b0 || code_out !== second) begin
      tests_failed++;
      $display("FAIL prio_drain: got v=%0b c=%0d, required v=0 c=%0d", valid, code_out, second);
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL prio_outstanding: got %0d left, required 0", exp_q.size());
    end
  endtask

  task automatic test_hold_dup();
    ready  = 1'b0;
    req_in = 4'b1000;
    exp_q.push_back(2'd3);
    step();
    req_in = '0;
    step();
    tests_run++;
    if (valid !== 1'b1 || code_out !== 2'd3) begin
      tests_failed++;
      $display("FAIL hold_load: got v=%0b c=%0d, required v=1 c=3", valid, code_out);
    end
    req_in = 4'b0010;
    exp_q.push_back(2'd1);
    step();
    tests_run++;
    if (dup_pulse !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_first_pulse_dup: got %0b, required 0", dup_pulse);
    end
    step();
    req_in = '0;
    tests_run++;
    if (dup_pulse !== 1'b1) begin
      tests_failed++;
      $display("FAIL hold_second_pulse_dup: got %0b, required 1", dup_pulse);
    end
    tests_run++;
    if (valid !== 1'b1 || code_out !== 2'd3) begin
      tests_failed++;
      $display("FAIL hold_stable: got v=%0b c=%0d, required v=1 c=3", valid, code_out);
    end
    step();
    tests_run++;
    if (dup_pulse !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_dup_one_cycle: got %0b, required 0", dup_pulse);
    end
    ready = 1'b1;
    repeat (4) step();
    tests_run++;
    if (valid !== 1'b0 || any_pending !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_drain: got v=%0b p=%0b, required 0 0", valid, any_pending);
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL hold_outstanding: got %0d left, required 0", exp_q.size());
    end
  endtask

  task automatic test_enable_mask();
    en     = 1'b0;
    ready  = 1'b1;
    req_in = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      tests_run++;
      if (valid !== 1'b0 || any_pending !== 1'b0 || dup_pulse !== 1'b0) begin
        tests_failed++;
        $display("FAIL mask_cycle%0d: got v=%0b p=%0b d=%0b, required 0 0 0",
                 i, valid, any_pending, dup_pulse);
      end
    end
    req_in = '0;
    en     = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    do_reset();
    ready  = 1'b1;
    req_in = 4'b1111;
    // Held for 8 edges then released: 11 codes in total.
    for (int i = 0; i < 11; i++) begin
`ifdef ROUND_ROBIN_EN
      exp_q.push_back(2'(i % 4));
`else
      if (i < 8) exp_q.push_back(2'd3);
      else exp_q.push_back(2'(10 - i));
`endif
    end
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 0) begin
        tests_run++;
        if (dup_pulse !== 1'b0) begin
          tests_failed++;
          $display("FAIL b2b_dup_first: got %0b, required 0", dup_pulse);
        end
      end
      if (i == 2) begin
        tests_run++;
        if (dup_pulse !== 1'b1) begin
          tests_failed++;
          $display("FAIL b2b_dup_merge: got %0b, required 1", dup_pulse);
        end
      end
    end
    req_in = '0;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
    step();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL b2b_timeout: got %0d codes outstanding, required 0", exp_q.size());
    end
    tests_run++;
    if (valid !== 1'b0 || any_pending !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_idle: got v=%0b p=%0b, required 0 0", valid, any_pending);
    end
  endtask

  task automatic test_async_reset();
    ready  = 1'b0;
    req_in = 4'b1000;
    step();
    req_in = 4'b0110;
    step();
    req_in = '0;
    step();
    tests_run++;
    if (valid !== 1'b1 || any_pending !== 1'b1) begin
      tests_failed++;
      $display("FAIL async_setup: got v=%0b p=%0b, required 1 1", valid, any_pending);
    end
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    tests_run++;
    if (valid !== 1'b0 || code_out !== 2'd0 || any_pending !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: got v=%0b c=%0d p=%0b, required 0 0 0",
               valid, code_out, any_pending);
    end
    step();
    reset_n = 1'b1;
    step();
    step();
    tests_run++;
    if (valid !== 1'b0 || any_pending !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_after: got v=%0b p=%0b, required 0 0", valid, any_pending);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_n      = 1'b0;
    en           = 1'b1;
    req_in       = '0;
    ready        = 1'b0;
    #1;
    test_reset();
    test_priority();
    test_hold_dup();
    test_enable_mask();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
